// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the RAM BIST controller.
// The state enum always lists the address-pattern states so encodings stay stable across builds.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_BG  = 3'd1,
        RD_BG  = 3'd2,
        WR_INV = 3'd3,
        RD_INV = 3'd4,
        WR_ADR = 3'd5,
        RD_ADR = 3'd6,
        DONE   = 3'd7
    } state_t;

    localparam logic [3:0] PAT_DEFAULT = 4'hA;

endpackage

// File: rtl/ram_bist_if.sv
// Test-controller and RAM port bundle of the BIST controller.
// master = the BIST controller; slave = test controller plus RAM.
interface ram_bist_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
);
    logic              start;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W-1:0] fail_addr;
    logic              write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              read_en;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] read_data;

    modport master (
        input  start, read_data,
        output busy, done, pass, fail_addr,
        output write_en, write_addr, write_data, read_en, read_addr
    );

    modport slave (
        output start, read_data,
        input  busy, done, pass, fail_addr,
        input  write_en, write_addr, write_data, read_en, read_addr
    );
endinterface

// File: rtl/ram_bist_addr_gen.sv
// Address counter shared by every BIST phase: clear to zero, count up, flag DEPTH-1.
module ram_bist_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr <= '0;
        else if (clr)
            addr <= '0;
        else if (inc)
            addr <= addr + ADDR_W'(1);
    end

    assign last = (addr == ADDR_W'(DEPTH - 1));

endmodule

// File: rtl/ram_bist_ctrl.sv
// March-style RAM BIST: write PAT, read-compare, write ~PAT, read-compare, report first failing address.
// Optional RAM_BIST_ADDR_PAT_EN adds an address-as-data write/read pass to catch address aliasing.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W = 8,
    parameter int                DATA_W = 4,
    parameter int                DEPTH  = 8,
    parameter logic [DATA_W-1:0] PAT    = DATA_W'(PAT_DEFAULT)
) (
    input logic      clk,
    input logic      rst_n,
    ram_bist_if.master bus
);

    state_t            state, state_next;
    logic              drain, drain_next;
    logic              clr, inc, last;
    logic [ADDR_W-1:0] addr;
    logic              is_write;
    logic              wr_en, rd_en;
    logic [DATA_W-1:0] wr_data, exp_data;
    logic              mismatch;
    logic              vld_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic              pass;
    logic [ADDR_W-1:0] fail_addr;

`ifdef RAM_BIST_ADDR_PAT_EN
    function automatic logic [DATA_W-1:0] addr_pat(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W && i < ADDR_W; i++)
            r[i] = a[i];
        return r;
    endfunction
`endif

    function automatic state_t next_phase(input state_t s);
        case (s)
            WR_BG:   return RD_BG;
            RD_BG:   return WR_INV;
            WR_INV:  return RD_INV;
`ifdef RAM_BIST_ADDR_PAT_EN
            RD_INV:  return WR_ADR;
            WR_ADR:  return RD_ADR;
`endif
            default: return DONE;
        endcase
    endfunction

    ram_bist_addr_gen #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (inc),
        .addr  (addr),
        .last  (last)
    );

    // Compare stage: read_data returns one cycle after the request tagged by vld_p0/addr_p0.
    always_comb begin
        exp_data = (state == RD_INV) ? ~PAT : PAT;
        wr_data  = (state == WR_INV) ? ~PAT : PAT;
        is_write = (state == WR_BG) || (state == WR_INV);
`ifdef RAM_BIST_ADDR_PAT_EN
        if (state == RD_ADR) exp_data = addr_pat(addr_p0);
        if (state == WR_ADR) wr_data = addr_pat(addr);
        is_write = is_write || (state == WR_ADR);
`endif
    end

    assign mismatch = vld_p0 && (bus.read_data != exp_data);

    always_comb begin
        state_next = state;
        drain_next = drain;
        clr        = 1'b0;
        inc        = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        if (state == IDLE) begin
            clr        = 1'b1;
            drain_next = 1'b0;
            if (bus.start) state_next = WR_BG;
        end else if (state == DONE) begin
            drain_next = 1'b0;
            state_next = IDLE;
        end else if (is_write) begin
            wr_en = 1'b1;
            inc   = 1'b1;
            if (last) begin
                clr        = 1'b1;
                state_next = next_phase(state);
            end
        end else if (mismatch) begin
            // Abort without issuing another access.
            state_next = DONE;
        end else if (drain) begin
            drain_next = 1'b0;
            clr        = 1'b1;
            state_next = next_phase(state);
        end else begin
            rd_en = 1'b1;
            if (last) drain_next = 1'b1;
            else      inc = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            drain     <= 1'b0;
            vld_p0    <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
        end else begin
            state  <= state_next;
            drain  <= drain_next;
            vld_p0 <= rd_en;
            if (state == IDLE && bus.start) begin
                pass      <= 1'b0;
                fail_addr <= '0;
            end else if (state != DONE && state_next == DONE) begin
                pass      <= !mismatch;
                fail_addr <= mismatch ? addr_p0 : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        addr_p0 <= rd_en ? addr : '0;
    end

    assign bus.busy       = (state != IDLE) && (state != DONE);
    assign bus.done       = (state == DONE);
    assign bus.pass       = pass;
    assign bus.fail_addr  = fail_addr;
    assign bus.write_en   = wr_en;
    assign bus.write_addr = wr_en ? addr : '0;
    assign bus.write_data = wr_en ? wr_data : '0;
    assign bus.read_en    = rd_en;
    assign bus.read_addr  = rd_en ? addr : '0;

endmodule
